// File: rtl/qpmm_iter.sv
// qpmm_iter: digit-serial Montgomery multiplier with a runtime modulus.
//
// Computes Z = A*B*R^-1 mod M with R = 2^(DIGIT_W*N_DIGITS). One digit of A
// is consumed per cycle. The default result is lazily reduced (< 2M). An
// optional final conditional subtraction gives a fully reduced result (< M).
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready is high only when idle
//   in_a, in_b          operands (< 2M); in_b is ignored when in_sq=1
//   in_sq               square mode, B := A
//   in_full             1 = fully reduced result, 0 = lazy result
//   in_tag              sideband returned with the result
//   mod_m, mod_minv     modulus M (odd) and -M^-1 mod 2^DIGIT_W, sampled at accept
//   out_valid/out_ready result handshake
//   out_z, out_tag      result and its tag, held stable while out_valid=1

// Side checker: each Montgomery step must clear the low digit, which the
// following shift then discards.
module qpmm_iter_chk #(
  parameter int DIGIT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               calc_active,
  input  logic [DIGIT_W-1:0] low_bits
);

  a_low_digit_zero: assert property (@(posedge clk) disable iff (rst)
    calc_active |-> (low_bits == {DIGIT_W{1'b0}}));

endmodule

module qpmm_iter #(
  parameter int DATA_W   = 384,
  parameter int DIGIT_W  = 16,
  parameter int N_DIGITS = 25,
  parameter int TAG_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic               in_sq,
  input  logic               in_full,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [DATA_W-1:0]  mod_m,
  input  logic [DIGIT_W-1:0] mod_minv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_z,
  output logic [TAG_W-1:0]   out_tag
);

  // Accumulator width: S + a_i*B + q*M stays below 2^SW for legal inputs.
  localparam int SW    = DATA_W + DIGIT_W + 2;
  // A is zero-padded up to a whole number of digits.
  localparam int AW    = DIGIT_W * N_DIGITS;
  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  // WB is the write-back cycle that registers the result onto out_z.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_RED  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             state_q,     state_d;
  logic [AW-1:0]      a_q,         a_d;
  logic [DATA_W-1:0]  b_q,         b_d;
  logic [DATA_W-1:0]  m_q,         m_d;
  logic [DIGIT_W-1:0] minv_q,      minv_d;
  logic               full_q,      full_d;
  logic [TAG_W-1:0]   tag_q,       tag_d;
  logic [SW-1:0]      s_q,         s_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [DATA_W-1:0]  out_z_q,     out_z_d;
  logic [TAG_W-1:0]   out_tag_q,   out_tag_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q,  in_ready_d;

  logic [DIGIT_W-1:0] digit_s;
  logic [DIGIT_W-1:0] q_s;
  logic [SW-1:0]      m_ext_s;
  logic [SW-1:0]      s1_s;
  logic [SW-1:0]      t_s;
  logic [SW-1:0]      s_step_s;
  logic [SW-1:0]      s_red_s;
  logic               last_s;

  // One Montgomery digit step and the conditional final subtraction.
  always_comb begin
    // A is shifted right each step, so the current digit is always at the bottom.
    digit_s  = a_q[DIGIT_W-1:0];
    m_ext_s  = SW'(m_q);
    s1_s     = s_q + SW'(digit_s) * SW'(b_q);
    // Only the low digit of the product is needed: q is taken mod 2^DIGIT_W.
    q_s      = s1_s[DIGIT_W-1:0] * minv_q;
    t_s      = s1_s + SW'(q_s) * m_ext_s;
    s_step_s = t_s >> DIGIT_W;
    if (s_q >= m_ext_s) begin
      s_red_s = s_q - m_ext_s;
    end else begin
      s_red_s = s_q;
    end
    last_s = (cnt_q == CNT_W'(N_DIGITS - 1));
  end

  // Next-state and register-update logic for the operation sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    minv_d      = minv_q;
    full_d      = full_q;
    tag_d       = tag_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    out_z_d     = out_z_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = AW'(in_a);
          b_d        = in_sq ? in_a : in_b;
          m_d        = mod_m;
          minv_d     = mod_minv;
          full_d     = in_full;
          tag_d      = in_tag;
          s_d        = {SW{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          state_d    = ST_CALC;
        end else begin
          in_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_CALC: begin
        s_d = s_step_s;
        a_d = a_q >> DIGIT_W;
        if (last_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = full_q ? ST_RED : ST_WB;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_CALC;
        end
      end
      ST_RED: begin
        s_d     = s_red_s;
        state_d = ST_WB;
      end
      ST_WB: begin
        out_z_d     = s_q[DATA_W-1:0];
        out_tag_d   = tag_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= {AW{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      m_q         <= {DATA_W{1'b0}};
      minv_q      <= {DIGIT_W{1'b0}};
      full_q      <= 1'b0;
      tag_q       <= {TAG_W{1'b0}};
      s_q         <= {SW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_z_q     <= {DATA_W{1'b0}};
      out_tag_q   <= {TAG_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      minv_q      <= minv_d;
      full_q      <= full_d;
      tag_q       <= tag_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      out_z_q     <= out_z_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_tag   = out_tag_q;

  qpmm_iter_chk #(
    .DIGIT_W (DIGIT_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .calc_active (state_q == ST_CALC),
    .low_bits    (t_s[DIGIT_W-1:0])
  );

endmodule

// File: tb/tb_qpmm_iter.sv
// Testbench for qpmm_iter: a small instance (9-bit data, 4-bit digits, M=251)
// for directed cases and a default-size instance with the BLS12-381 modulus
// for randomized traffic checked against a bit-serial REDC reference model.
module tb_qpmm_iter;

  localparam int SD = 9;
  localparam int SG = 4;
  localparam int SN = 3;
  localparam int ST = 8;
  localparam int BD = 384;
  localparam int BG = 16;
  localparam int BN = 25;
  localparam int BT = 8;
  localparam int TW = 2 * BD + 2;
  localparam int NOPS = 200;
  localparam logic [BD-1:0] P_BLS = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic          s_rst, s_in_valid, s_in_ready, s_in_sq, s_in_full, s_out_valid, s_out_ready;
  logic [SD-1:0] s_in_a, s_in_b, s_mod_m, s_out_z;
  logic [SG-1:0] s_mod_minv;
  logic [ST-1:0] s_in_tag, s_out_tag;

  logic          b_rst, b_in_valid, b_in_ready, b_in_sq, b_in_full, b_out_valid, b_out_ready;
  logic [BD-1:0] b_in_a, b_in_b, b_mod_m, b_out_z;
  logic [BG-1:0] b_mod_minv;
  logic [BT-1:0] b_in_tag, b_out_tag;

  typedef struct { logic [SD-1:0] z; logic [ST-1:0] tag; } s_exp_t;
  typedef struct { logic [BD-1:0] z; logic full; logic [BT-1:0] tag; } b_exp_t;
  s_exp_t s_sb[$];
  b_exp_t b_sb[$];

  qpmm_iter #(.DATA_W(SD), .DIGIT_W(SG), .N_DIGITS(SN), .TAG_W(ST)) u_small (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_sq(s_in_sq), .in_full(s_in_full), .in_tag(s_in_tag),
    .mod_m(s_mod_m), .mod_minv(s_mod_minv), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_z(s_out_z), .out_tag(s_out_tag));

  qpmm_iter #(.DATA_W(BD), .DIGIT_W(BG), .N_DIGITS(BN), .TAG_W(BT)) u_big (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_sq(b_in_sq), .in_full(b_in_full), .in_tag(b_in_tag),
    .mod_m(b_mod_m), .mod_minv(b_mod_minv), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_z(b_out_z), .out_tag(b_out_tag));

  // Bit-serial REDC: adding M when odd and halving multiplies by 2^-1 mod M.
  function automatic logic [BD-1:0] mont_ref(input logic [BD-1:0] a, input logic [BD-1:0] b,
                                             input logic [BD-1:0] m);
    logic [TW-1:0] t;
    t = TW'(a) * TW'(b);
    for (int i = 0; i < BG * BN; i++) begin
      if (t[0]) t = t + TW'(m);
      t = t >> 1;
    end
    t = t % TW'(m);
    return t[BD-1:0];
  endfunction

  function automatic logic [BD-1:0] rand_below_2m();
    logic [BD-1:0] r;
    logic [BD-1:0] two_m;
    two_m = P_BLS << 1;
    for (int k = 0; k < BD / 32; k++) r[k*32 +: 32] = $urandom();
    return r % two_m;
  endfunction

  task automatic small_send(input logic [SD-1:0] a, input logic [SD-1:0] b, input logic sq,
                            input logic full, input logic [ST-1:0] tag, output logic ok);
    int n;
    ok = 1'b0;
    @(negedge clk);
    s_in_a = a; s_in_b = b; s_in_sq = sq; s_in_full = full; s_in_tag = tag;
    s_in_valid = 1'b1;
    n = 0;
    while (!s_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (s_in_ready) begin
      @(posedge clk);
      ok = 1'b1;
    end
    #1;
    s_in_valid = 1'b0;
  endtask

  // Returns the number of clock edges from the accept edge to out_valid.
  task automatic small_wait(output logic [SD-1:0] z, output logic [ST-1:0] tag, output int lat);
    lat = -1; z = '0; tag = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_out_valid) begin
        lat = k; z = s_out_z; tag = s_out_tag;
        break;
      end
    end
  endtask

  task automatic small_drain();
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    s_rst = 1'b1; b_rst = 1'b1;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", s_in_ready); end
    checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", s_out_valid); end
    checks++; if (s_out_z !== 9'd0) begin failures++; $display("FAIL reset_out_z: got %0d expected 0", s_out_z); end
    checks++; if (s_out_tag !== 8'd0) begin failures++; $display("FAIL reset_out_tag: got %0d expected 0", s_out_tag); end
    checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_big: in_ready=%b out_valid=%b expected 1/0", b_in_ready, b_out_valid); end
    repeat (2) @(negedge clk);
    s_rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_lazy_one();
    logic ok; logic [SD-1:0] z; logic [ST-1:0] tag; int lat; s_exp_t e;
    s_sb.push_back('{z: 9'd100, tag: 8'h5A});
    small_send(9'd80, 9'd100, 1'b0, 1'b0, 8'h5A, ok);
    // The in-flight operation must keep the modulus it latched.
    s_mod_m = 9'd0; s_mod_minv = 4'd0;
    small_wait(z, tag, lat);
    e = s_sb.pop_front();
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lazy_accept: got %b expected 1", ok); end
    checks++; if (z !== e.z) begin failures++; $display("FAIL lazy_z: got %0d expected %0d", z, e.z); end
    checks++; if (tag !== e.tag) begin failures++; $display("FAIL lazy_tag: got %h expected %h", tag, e.tag); end
    checks++; if (lat != 4) begin failures++; $display("FAIL lazy_latency: got %0d expected 4", lat); end
    small_drain();
    s_mod_m = 9'd251; s_mod_minv = 4'd13;
  endtask

  task automatic test_square_full();
    logic ok; logic [SD-1:0] z; logic [ST-1:0] tag; int lat; s_exp_t e;
    s_sb.push_back('{z: 9'd80, tag: 8'hC3});
    small_send(9'd80, 9'h1FF, 1'b1, 1'b1, 8'hC3, ok);
    small_wait(z, tag, lat);
    e = s_sb.pop_front();
    checks++; if (z !== e.z) begin failures++; $display("FAIL square_z: got %0d expected %0d", z, e.z); end
    checks++; if (tag !== e.tag) begin failures++; $display("FAIL square_tag: got %h expected %h", tag, e.tag); end
    checks++; if (lat != 5) begin failures++; $display("FAIL square_latency: got %0d expected 5", lat); end
    small_drain();
  endtask

  task automatic test_full_reduction();
    logic ok; logic [SD-1:0] z; logic [ST-1:0] tag; int lat; s_exp_t e;
    s_sb.push_back('{z: 9'd91, tag: 8'h01});
    small_send(9'd501, 9'd501, 1'b0, 1'b1, 8'h01, ok);
    small_wait(z, tag, lat);
    e = s_sb.pop_front();
    checks++; if (z !== e.z) begin failures++; $display("FAIL full_z: got %0d expected %0d", z, e.z); end
    checks++; if (lat != 5) begin failures++; $display("FAIL full_latency: got %0d expected 5", lat); end
    small_drain();
    s_sb.push_back('{z: 9'd91, tag: 8'h02});
    small_send(9'd501, 9'd501, 1'b0, 1'b0, 8'h02, ok);
    small_wait(z, tag, lat);
    e = s_sb.pop_front();
    checks++; if ((z % 9'd251) !== e.z || z >= 9'd502) begin failures++; $display("FAIL lazy501_z: got %0d expected congruent to %0d and below 502", z, e.z); end
    checks++; if (tag !== e.tag || lat != 4) begin failures++; $display("FAIL lazy501_tag_lat: got tag %h lat %0d expected %h 4", tag, lat, e.tag); end
    small_drain();
  endtask

  task automatic test_same_cycle_ready();
    logic ok; logic [SD-1:0] z; logic [ST-1:0] tag; int lat; s_exp_t e;
    s_out_ready = 1'b1;
    s_sb.push_back('{z: 9'd100, tag: 8'h77});
    small_send(9'd80, 9'd100, 1'b0, 1'b0, 8'h77, ok);
    small_wait(z, tag, lat);
    e = s_sb.pop_front();
    checks++; if (z !== e.z || tag !== e.tag) begin failures++; $display("FAIL early_ready_result: got %0d/%h expected %0d/%h", z, tag, e.z, e.tag); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin failures++; $display("FAIL early_ready_release: out_valid=%b in_ready=%b expected 0/1", s_out_valid, s_in_ready); end
    s_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic ok; logic [SD-1:0] z; logic [ST-1:0] tag; int lat; int bad; s_exp_t e;
    s_sb.push_back('{z: 9'd100, tag: 8'h3C});
    small_send(9'd80, 9'd100, 1'b0, 1'b0, 8'h3C, ok);
    small_wait(z, tag, lat);
    e = s_sb.pop_front();
    checks++; if (z !== e.z || tag !== e.tag) begin failures++; $display("FAIL bp_result: got %0d/%h expected %0d/%h", z, tag, e.z, e.tag); end
    // Producer presents the next request while the block is still busy.
    s_in_a = 9'd0; s_in_b = 9'd377; s_in_sq = 1'b0; s_in_full = 1'b0; s_in_tag = 8'h11;
    s_in_valid = 1'b1;
    s_sb.push_back('{z: 9'd0, tag: 8'h11});
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_out_valid !== 1'b1 || s_out_z !== z || s_out_tag !== tag || s_in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    s_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drop_valid: got %b expected 0", s_out_valid); end
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back: got %b expected 1", s_in_ready); end
    s_out_ready = 1'b0;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    small_wait(z, tag, lat);
    e = s_sb.pop_front();
    checks++; if (z !== e.z) begin failures++; $display("FAIL zero_z: got %0d expected %0d", z, e.z); end
    checks++; if (tag !== e.tag || lat != 4) begin failures++; $display("FAIL zero_tag_lat: got %h/%0d expected %h/4", tag, lat, e.tag); end
    small_drain();
  endtask

  task automatic test_reset_mid_op();
    logic ok; logic [SD-1:0] z; logic [ST-1:0] tag; int lat; int bad; s_exp_t e;
    small_send(9'd80, 9'd100, 1'b0, 1'b0, 8'h21, ok);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    s_rst = 1'b1;
    #1;
    checks++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_async: in_ready=%b out_valid=%b expected 1/0", s_in_ready, s_out_valid); end
    @(negedge clk);
    s_rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_quiet: got %0d bad cycles expected 0", bad); end
    s_sb.push_back('{z: 9'd100, tag: 8'h22});
    small_send(9'd80, 9'd100, 1'b0, 1'b0, 8'h22, ok);
    small_wait(z, tag, lat);
    e = s_sb.pop_front();
    checks++; if (z !== e.z || tag !== e.tag || lat != 4) begin failures++; $display("FAIL midrst_next: got %0d/%h/%0d expected %0d/%h/4", z, tag, lat, e.z, e.tag); end
    small_drain();
  endtask

  task automatic test_random_big();
    int got;
    logic drv_to;
    logic [BD-1:0] two_m;
    got = 0; drv_to = 1'b0;
    two_m = P_BLS << 1;
    b_mod_m = P_BLS; b_mod_minv = 16'hFFFD;
    fork
      begin
        for (int i = 0; i < NOPS && !drv_to; i++) begin
          logic [BD-1:0] a, b; logic sq, full; b_exp_t e; int n;
          a = rand_below_2m(); b = rand_below_2m();
          if (i == 0) a = '0;
          if (i == 1) begin a = two_m - 1; b = two_m - 1; end
          sq = ($urandom_range(0, 3) == 0);
          full = 1'($urandom_range(0, 1));
          @(negedge clk);
          b_in_a = a; b_in_b = b; b_in_sq = sq; b_in_full = full; b_in_tag = BT'(i);
          b_in_valid = 1'b1;
          n = 0;
          while (!b_in_ready && n < 200) begin
            @(negedge clk);
            n++;
          end
          if (b_in_ready) begin
            e.z = mont_ref(a, sq ? a : b, P_BLS); e.full = full; e.tag = BT'(i);
            b_sb.push_back(e);
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
          end else begin
            drv_to = 1'b1;
          end
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < NOPS && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          b_out_ready = ($urandom_range(0, 3) != 0);
          if (b_out_valid && b_out_ready) begin
            b_exp_t e;
            checks++;
            if (b_sb.size() == 0) begin
              failures++; $display("FAIL big_unexpected: got output tag %h expected none", b_out_tag);
            end else begin
              e = b_sb.pop_front();
              if (b_out_tag !== e.tag) begin failures++; $display("FAIL big_tag: got %h expected %h", b_out_tag, e.tag); end
              checks++;
              if (e.full) begin
                if (b_out_z !== e.z) begin failures++; $display("FAIL big_full_z: got %h expected %h", b_out_z, e.z); end
              end else begin
                if ((b_out_z % P_BLS) !== e.z || b_out_z >= two_m) begin failures++; $display("FAIL big_lazy_z: got %h expected congruent to %h below 2M", b_out_z, e.z); end
              end
            end
            got++;
          end
        end
      end
    join
    b_out_ready = 1'b0;
    checks++; if (drv_to !== 1'b0) begin failures++; $display("FAIL big_accept_timeout: got %b expected 0", drv_to); end
    checks++; if (got != NOPS) begin failures++; $display("FAIL big_count: got %0d expected %0d", got, NOPS); end
  endtask

  initial begin
    s_rst = 1'b0; s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_sq = 1'b0; s_in_full = 1'b0;
    s_in_tag = '0; s_mod_m = 9'd251; s_mod_minv = 4'd13; s_out_ready = 1'b0;
    b_rst = 1'b0; b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_sq = 1'b0; b_in_full = 1'b0;
    b_in_tag = '0; b_mod_m = P_BLS; b_mod_minv = 16'hFFFD; b_out_ready = 1'b0;
    test_reset();
    test_lazy_one();
    test_square_full();
    test_full_reduction();
    test_same_cycle_ready();
    test_backpressure();
    test_reset_mid_op();
    test_random_big();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
